// File: rtl/wb_ram_bridge.sv
// Wishbone classic slave bridging one address window onto a 256-word byte-writable sync SRAM.
// Optional one-entry read cache is compiled in when WB_RAM_RDCACHE_EN is defined.
module wb_ram_bridge #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [31:0] ADR_MASK = 32'hFFFF_FC00
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              ram_en0,
  output logic [ADDR_W-1:0] ram_a0,
  output logic [31:0]       ram_di0,
  output logic [3:0]        ram_we0,
  input  logic [31:0]       ram_do0
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, ACK} state_t;

  state_t              state_q, state_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [31:0]         di_q, di_d;
  logic [3:0]          we_q, we_d;
  logic                wr_q, wr_d;

  logic                hit;
  logic [ADDR_W-1:0]   word_adr;
  logic                cache_hit;
  logic [31:0]         cache_data;

  assign word_adr = wbs_adr_i[ADDR_W+1:2];
  // ~ack keeps a strobe still held through the ack cycle from starting a second transfer
  assign hit = wbs_cyc_i & wbs_stb_i & ~ack_q &
               ((wbs_adr_i & ADR_MASK) == (BASE_ADR & ADR_MASK));

`ifdef WB_RAM_RDCACHE_EN
  logic              cv_q, cv_d;
  logic [ADDR_W-1:0] ca_q, ca_d;
  logic [31:0]       cd_q, cd_d;

  always_comb begin
    cv_d = cv_q;
    ca_d = ca_q;
    cd_d = cd_q;
    if (state_q == IDLE && hit && wbs_we_i && ca_q == word_adr) begin
      cv_d = 1'b0;
    end
    if (state_q == RDATA && wbs_cyc_i) begin
      cv_d = 1'b1;
      ca_d = a_q;
      cd_d = ram_do0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cv_q <= 1'b0;
      ca_q <= '0;
      cd_q <= '0;
    end else begin
      cv_q <= cv_d;
      ca_q <= ca_d;
      cd_q <= cd_d;
    end
  end

  assign cache_hit  = ~wbs_we_i & cv_q & (ca_q == word_adr);
  assign cache_data = cd_q;
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      en_q    <= 1'b0;
      a_q     <= '0;
      di_q    <= '0;
      we_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      a_q     <= a_d;
      di_q    <= di_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = cache_hit ? ACK : ACCESS;
      ACCESS:  if (!wbs_cyc_i) state_d = IDLE;
               else state_d = wr_q ? ACK : RDATA;
      RDATA:   state_d = wbs_cyc_i ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers; address and write data hold, strobes default low
  always_comb begin
    ack_d = 1'b0;
    dat_d = dat_q;
    en_d  = 1'b0;
    a_d   = a_q;
    di_d  = di_q;
    we_d  = 4'b0;
    wr_d  = wr_q;
    case (state_q)
      IDLE: begin
        if (hit && cache_hit) begin
          dat_d = cache_data;
          ack_d = 1'b1;
        end else if (hit) begin
          a_d  = word_adr;
          di_d = wbs_dat_i;
          en_d = 1'b1;
          we_d = wbs_we_i ? wbs_sel_i : 4'b0;
          wr_d = wbs_we_i;
        end
      end
      ACCESS: begin
        if (wbs_cyc_i) begin
          ack_d = wr_q;
          en_d  = ~wr_q;
        end
      end
      RDATA: begin
        if (wbs_cyc_i) begin
          dat_d = ram_do0;
          ack_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ram_en0   = en_q;
  assign ram_a0    = a_q;
  assign ram_di0   = di_q;
  assign ram_we0   = we_q;

endmodule

// File: tb/tb_wb_ram_bridge.sv
// Directed bench for wb_ram_bridge: SRAM stand-in, timeline model of expected ack/strobes/data,
// per-cycle compare process plus literal checks. Define WB_RAM_RDCACHE_EN to test the cache build.
module tb_wb_ram_bridge;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ram_en0;
  logic [7:0]  ram_a0;
  logic [31:0] ram_di0;
  logic [3:0]  ram_we0;
  logic [31:0] ram_do0 = 32'h0;

`ifdef WB_RAM_RDCACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_FC00;
  localparam int          NCYC = 2048;

  wb_ram_bridge dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .ram_en0  (ram_en0),
    .ram_a0   (ram_a0),
    .ram_di0  (ram_di0),
    .ram_we0  (ram_we0),
    .ram_do0  (ram_do0)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc_cnt = 0;
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  // SRAM stand-in: byte-writable, data out one cycle after the enabled edge
  logic [31:0] sram [0:255];
  always @(posedge wb_clk_i) begin
    if (ram_en0) begin
      for (int b = 0; b < 4; b++)
        if (ram_we0[b]) sram[ram_a0][8*b +: 8] <= ram_di0[8*b +: 8];
      ram_do0 <= sram[ram_a0];
    end
  end

  // Reference model: memory image, cache image and per-cycle expectation timeline
  logic [31:0] ref_mem [0:255];
  bit          exp_ack [0:NCYC-1];
  bit          exp_en  [0:NCYC-1];
  bit [3:0]    exp_we  [0:NCYC-1];
  bit          exp_rd  [0:NCYC-1];
  bit [31:0]   exp_dat [0:NCYC-1];
  bit          mc_v = 1'b0;
  logic [7:0]  mc_a = 8'h0;
  logic [31:0] cur_dat = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      cur_dat = 32'h0;
    end else if (cyc_cnt < NCYC) begin
      if (exp_rd[cyc_cnt]) cur_dat = exp_dat[cyc_cnt];
      chk("ack",    {31'b0, wbs_ack_o}, {31'b0, exp_ack[cyc_cnt]});
      chk("ram_en", {31'b0, ram_en0},   {31'b0, exp_en[cyc_cnt]});
      chk("ram_we", {28'b0, ram_we0},   {28'b0, exp_we[cyc_cnt]});
      chk("dat_o",  wbs_dat_o, cur_dat);
    end
  end

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit hold,
                      output int lat, output logic [31:0] rdat);
    int         t;
    logic [7:0] w;
    @(negedge wb_clk_i);
    #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    t = cyc_cnt;
    w = adr[9:2];
    if ((adr & MASK) != (BASE & MASK)) begin
      // no expectations: the timeline stays all-zero
    end else if (we) begin
      exp_en[t+1]  = 1'b1;
      exp_we[t+1]  = sel;
      exp_ack[t+2] = 1'b1;
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
      if (mc_a == w) mc_v = 1'b0;
    end else if (CACHE_ON && mc_v && mc_a == w) begin
      exp_ack[t+1] = 1'b1;
      exp_rd[t+1]  = 1'b1;
      exp_dat[t+1] = ref_mem[w];
    end else begin
      exp_en[t+1]  = 1'b1;
      exp_en[t+2]  = 1'b1;
      exp_ack[t+3] = 1'b1;
      exp_rd[t+3]  = 1'b1;
      exp_dat[t+3] = ref_mem[w];
      mc_v = 1'b1;
      mc_a = w;
    end
    lat  = 0;
    rdat = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        lat  = i;
        rdat = wbs_dat_o;
        break;
      end
    end
    #1;
    if (!hold) begin
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
    end
    $display("[TB] xfer we=%0d adr=%h dat=%h sel=%h -> lat=%0d rdat=%h", we, adr, dat, sel, lat, rdat);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ack"}, {31'b0, wbs_ack_o}, 32'h0);
    chk({tag, "_dat"}, wbs_dat_o, 32'h0);
    chk({tag, "_en"},  {31'b0, ram_en0}, 32'h0);
    chk({tag, "_a0"},  {24'b0, ram_a0}, 32'h0);
    chk({tag, "_di"},  ram_di0, 32'h0);
    chk({tag, "_we"},  {28'b0, ram_we0}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          t;
    logic [31:0] rd;
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 32'h5A5A_0000 + i;
      ref_mem[i] = 32'h5A5A_0000 + i;
    end

    repeat (3) @(negedge wb_clk_i);
    chk_zero_outputs("reset");
    #1 wb_rst_i = 1'b0;

    // full-word write then readback
    xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, lat, rd);
    chk("wr_lat", lat, 2);
    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, lat, rd);
    chk("rd_lat", lat, 3);
    chk("rd_data", rd, 32'hDEAD_BEEF);

    // byte-lane merge
    xfer(1'b1, 32'h3000_0014, 32'h1122_3344, 4'hF, 1'b0, lat, rd);
    xfer(1'b1, 32'h3000_0014, 32'h00AA_0000, 4'b0100, 1'b0, lat, rd);
    xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, 1'b0, lat, rd);
    chk("lane_data", rd, 32'h11AA_3344);

    // sel=0 write still acks, changes nothing (and drops any cached copy)
    xfer(1'b1, 32'h3000_0014, 32'hFFFF_FFFF, 4'h0, 1'b0, lat, rd);
    chk("sel0_lat", lat, 2);
    xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, 1'b0, lat, rd);
    chk("sel0_rd_lat", lat, 3);
    chk("sel0_data", rd, 32'h11AA_3344);

    // back-to-back with stb held through each ack
    xfer(1'b1, 32'h3000_0018, 32'hCAFE_F00D, 4'hF, 1'b1, lat, rd);
    chk("b2b_wr_lat", lat, 2);
    xfer(1'b0, 32'h3000_0018, 32'h0, 4'hF, 1'b1, lat, rd);
    chk("b2b_rd_lat", lat, 3);
    chk("b2b_rd_data", rd, 32'hCAFE_F00D);
    xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, lat, rd);
    chk("b2b_rd2_data", rd, 32'hDEAD_BEEF);

    // out-of-window access
    xfer(1'b1, 32'h3000_0400, 32'h1234_5678, 4'hF, 1'b0, lat, rd);
    chk("oow_no_ack", lat, 0);
    xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, lat, rd);
    chk("oow_no_write", rd, 32'h5A5A_0000);

    // read cache behaviour (plain 3-cycle reads when the cache is not built)
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b0, lat, rd);
    chk("c_rd1_lat", lat, 3);
    chk("c_rd1_data", rd, 32'h5A5A_0008);
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b0, lat, rd);
    chk("c_rd2_lat", lat, CACHE_ON ? 1 : 3);
    chk("c_rd2_data", rd, 32'h5A5A_0008);
    xfer(1'b1, 32'h3000_0020, 32'h0BAD_F00D, 4'hF, 1'b0, lat, rd);
    xfer(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1'b0, lat, rd);
    chk("c_rd3_lat", lat, 3);
    chk("c_rd3_data", rd, 32'h0BAD_F00D);

    // reset asserted while the read sits in its data cycle
    @(negedge wb_clk_i);
    #1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = 32'h3000_0040;
    wbs_sel_i = 4'hF;
    t = cyc_cnt;
    exp_en[t+1] = 1'b1;
    exp_en[t+2] = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    #1;
    wb_rst_i  = 1'b1;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    mc_v      = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    $display("[TB] reset during read of 30000040 at cycle %0d", cyc_cnt);
    repeat (3) @(negedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    xfer(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0, lat, rd);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", rd, 32'h5A5A_0000);

    repeat (4) @(negedge wb_clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
